// File: rtl/l2_flush_engine.sv
`default_nettype none
// ============================================================================
//  Module      : l2_flush_engine
//  Description : Sequential flush sweeper for the L2 tag/valid/dirty/data
//                arrays. On request it visits every set once. Each valid and
//                dirty line is written back to memory, and then the set's
//                valid and dirty bits are cleared.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n             clock, synchronous active-low reset
//    flush_req              start a sweep (sampled in IDLE only)
//    busy, flush_done       sweep in progress / one-cycle completion pulse
//    arr_read, arr_load     array read enable / valid+dirty write enable
//    arr_index              set index to all arrays
//    arr_valid_in/dirty_in  valid/dirty datain (tied low)
//    valid_out, dirty_out,
//    tag_out, data_out      array dataouts (registered, 1-cycle latency)
//    mem_write, mem_address,
//    mem_wdata, mem_resp    memory write-back port
// ============================================================================
module l2_flush_engine #(
    parameter int s_index  = 3,
    parameter int s_offset = 5,
    parameter int s_tag    = 32 - s_index - s_offset,
    parameter int s_line   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_req,
    output logic                busy,
    output logic                flush_done,
    output logic                arr_read,
    output logic                arr_load,
    output logic [s_index-1:0]  arr_index,
    output logic                arr_valid_in,
    output logic                arr_dirty_in,
    input  logic                valid_out,
    input  logic                dirty_out,
    input  logic [s_tag-1:0]    tag_out,
    input  logic [s_line-1:0]   data_out,
    output logic                mem_write,
    output logic [31:0]         mem_address,
    output logic [s_line-1:0]   mem_wdata,
    input  logic                mem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WB    = 3'd3,
        ST_CLEAR = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [s_index-1:0] c_last_index = {s_index{1'b1}};

    state_t              r_state;
    logic [s_index-1:0]  r_count;
    logic [s_tag-1:0]    r_tag;
    logic [s_line-1:0]   r_data;

    // Cleared sets always get valid=0 and dirty=0.
    assign arr_valid_in = 1'b0;
    assign arr_dirty_in = 1'b0;

    // The write-back bus is built from the latched line and the current index.
    // Both are frozen for the whole WB stay, so address and data hold steady
    // until mem_resp. Gating with mem_write keeps the bus at zero elsewhere.
    assign mem_address = mem_write ? {r_tag, r_count, {s_offset{1'b0}}} : 32'd0;
    assign mem_wdata   = mem_write ? r_data : {s_line{1'b0}};

    // Outputs are registered. Each transition loads the values that belong
    // to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_tag      <= '0;
            r_data     <= '0;
            busy       <= 1'b0;
            flush_done <= 1'b0;
            arr_read   <= 1'b0;
            arr_load   <= 1'b0;
            arr_index  <= '0;
            mem_write  <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            arr_read   <= 1'b0;
            arr_load   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (flush_req) begin
                        r_state   <= ST_READ;
                        r_count   <= '0;
                        busy      <= 1'b1;
                        arr_read  <= 1'b1;
                        arr_index <= '0;
                    end
                end
                ST_READ: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    // The arrays present the set read in READ during this cycle.
                    r_tag  <= tag_out;
                    r_data <= data_out;
                    if (valid_out && dirty_out) begin
                        r_state   <= ST_WB;
                        mem_write <= 1'b1;
                    end else begin
                        r_state  <= ST_CLEAR;
                        arr_load <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (mem_resp) begin
                        r_state   <= ST_CLEAR;
                        mem_write <= 1'b0;
                        arr_load  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // The last index exits to DONE, so the counter never wraps.
                    if (r_count == c_last_index) begin
                        r_state    <= ST_DONE;
                        flush_done <= 1'b1;
                        arr_index  <= '0;
                    end else begin
                        r_state   <= ST_READ;
                        r_count   <= r_count + 1'b1;
                        arr_read  <= 1'b1;
                        arr_index <= r_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    mem_write <= 1'b0;
                    arr_index <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_flush_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_flush_engine
//  Description : Directed self-checking bench for l2_flush_engine, with a
//                behavioural model of the L2 arrays and a memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_flush_engine;

    localparam int c_index  = 3;
    localparam int c_offset = 5;
    localparam int c_tag    = 32 - c_index - c_offset;
    localparam int c_line   = 256;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush_req;
    logic                busy, flush_done, arr_read, arr_load;
    logic [c_index-1:0]  arr_index;
    logic                arr_valid_in, arr_dirty_in;
    logic                valid_out, dirty_out;
    logic [c_tag-1:0]    tag_out;
    logic [c_line-1:0]   data_out;
    logic                mem_write;
    logic [31:0]         mem_address;
    logic [c_line-1:0]   mem_wdata;
    logic                mem_resp;

    always #5 clk = ~clk;

    l2_flush_engine #(
        .s_index (c_index),
        .s_offset(c_offset),
        .s_tag   (c_tag),
        .s_line  (c_line)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req   (flush_req),
        .busy        (busy),
        .flush_done  (flush_done),
        .arr_read    (arr_read),
        .arr_load    (arr_load),
        .arr_index   (arr_index),
        .arr_valid_in(arr_valid_in),
        .arr_dirty_in(arr_dirty_in),
        .valid_out   (valid_out),
        .dirty_out   (dirty_out),
        .tag_out     (tag_out),
        .data_out    (data_out),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp)
    );

    // ---------------- array and memory models ----------------
    logic [7:0]        v_mem = 8'h00;
    logic [7:0]        d_mem = 8'h00;
    logic [7:0]        init_valid, init_dirty;
    logic              init_req;
    logic [c_tag-1:0]  tag_mem  [8];
    logic [c_line-1:0] data_mem [8];
    int                resp_delay;
    int                wb_cnt = 0;

    assign mem_resp = mem_write && (wb_cnt >= resp_delay);

    always @(posedge clk) begin
        if (init_req) begin
            v_mem <= init_valid;
            d_mem <= init_dirty;
        end else if (arr_load) begin
            v_mem[arr_index] <= arr_valid_in;
            d_mem[arr_index] <= arr_dirty_in;
        end
        if (arr_read) begin
            valid_out <= v_mem[arr_index];
            dirty_out <= d_mem[arr_index];
            tag_out   <= tag_mem[arr_index];
            data_out  <= data_mem[arr_index];
        end
        wb_cnt <= (mem_write && !mem_resp) ? wb_cnt + 1 : 0;
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passes = 0;
    int busy_cycles, load_cnt, load_order_err, wr_cycles, wr_done;
    int stable_err, done_cnt, overlap_err;
    bit first_read_ok, timed_out;
    logic [31:0]       cap_addr;
    logic [c_line-1:0] cap_data;

    task automatic load_arrays(input logic [7:0] vld, input logic [7:0] drt);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tag_mem[i]  = 24'h000100 + 24'(i);
            data_mem[i] = {32{8'h10 + 8'(i)}};
        end
        tag_mem[5]  = 24'h001234;
        data_mem[5] = {32{8'hA5}};
        tag_mem[6]  = 24'hABCDEF;
        data_mem[6] = {32{8'h5A}};
        init_valid = vld;
        init_dirty = drt;
        init_req   = 1'b1;
        @(negedge clk);
        init_req   = 1'b0;
    endtask

    // Pulse flush_req and observe one full sweep at negedges.
    task automatic run_sweep(input bit pulse_at_check4);
        bit                 prev_read;
        logic [c_index-1:0] prev_idx;
        int                 next_load;
        busy_cycles = 0; load_cnt = 0; load_order_err = 0; wr_cycles = 0;
        wr_done = 0; stable_err = 0; done_cnt = 0; overlap_err = 0;
        cap_addr = '0; cap_data = '0; timed_out = 1'b1;
        prev_read = 1'b0; prev_idx = '0; next_load = 0;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        first_read_ok = (busy === 1'b1) && (arr_read === 1'b1) && (arr_index === 3'd0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (busy !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            busy_cycles++;
            if (arr_read && arr_load) overlap_err++;
            if (arr_load) begin
                if (int'(arr_index) != next_load) load_order_err++;
                next_load++;
                load_cnt++;
            end
            if (mem_write) begin
                if (wr_cycles == 0) begin
                    cap_addr = mem_address;
                    cap_data = mem_wdata;
                end else if (mem_address !== cap_addr || mem_wdata !== cap_data) begin
                    stable_err++;
                end
                wr_cycles++;
                if (mem_resp) wr_done++;
            end
            if (flush_done) done_cnt++;
            flush_req = pulse_at_check4 && prev_read && (prev_idx == 3'd4);
            prev_read = arr_read;
            prev_idx  = arr_index;
            @(negedge clk);
        end
        flush_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else passes++;
        checks++; if (flush_done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", flush_done); else passes++;
        checks++; if ({arr_read, arr_load, mem_write} !== 3'b000)
            $display("FAIL rst_strobes: got %b expected 000", {arr_read, arr_load, mem_write}); else passes++;
        checks++; if (arr_index !== 3'd0 || mem_address !== 32'd0)
            $display("FAIL rst_index_addr: got %0h/%0h expected 0/0", arr_index, mem_address); else passes++;
        checks++; if (mem_wdata !== '0 || arr_valid_in !== 1'b0 || arr_dirty_in !== 1'b0)
            $display("FAIL rst_data: got %0h expected 0", mem_wdata); else passes++;
    endtask

    task automatic test_all_invalid();
        load_arrays(8'h00, 8'h00);
        run_sweep(1'b0);
        checks++; if (timed_out || busy_cycles !== 25) $display("FAIL inv_busy: got %0d expected 25", busy_cycles); else passes++;
        checks++; if (!first_read_ok) $display("FAIL inv_first_read: got 0 expected 1"); else passes++;
        checks++; if (load_cnt !== 8 || load_order_err !== 0)
            $display("FAIL inv_loads: got %0d (order err %0d) expected 8 (0)", load_cnt, load_order_err); else passes++;
        checks++; if (wr_cycles !== 0) $display("FAIL inv_nowrite: got %0d expected 0", wr_cycles); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL inv_done: got %0d expected 1", done_cnt); else passes++;
        checks++; if (overlap_err !== 0) $display("FAIL inv_overlap: got %0d expected 0", overlap_err); else passes++;
    endtask

    task automatic test_dirty_same_cycle();
        load_arrays(8'h20, 8'h20);
        resp_delay = 0;
        run_sweep(1'b0);
        checks++; if (timed_out || busy_cycles !== 26) $display("FAIL wb0_busy: got %0d expected 26", busy_cycles); else passes++;
        checks++; if (wr_cycles !== 1 || wr_done !== 1)
            $display("FAIL wb0_writes: got %0d/%0d expected 1/1", wr_cycles, wr_done); else passes++;
        checks++; if (cap_addr !== 32'h001234A0) $display("FAIL wb0_addr: got %0h expected 1234a0", cap_addr); else passes++;
        checks++; if (cap_data !== {32{8'hA5}}) $display("FAIL wb0_data: got %0h expected a5 pattern", cap_data); else passes++;
        checks++; if (v_mem !== 8'h00 || d_mem !== 8'h00)
            $display("FAIL wb0_cleared: got %0h/%0h expected 0/0", v_mem, d_mem); else passes++;
    endtask

    task automatic test_dirty_delayed();
        load_arrays(8'h20, 8'h20);
        resp_delay = 4;
        run_sweep(1'b0);
        checks++; if (timed_out || busy_cycles !== 30) $display("FAIL wb4_busy: got %0d expected 30", busy_cycles); else passes++;
        checks++; if (wr_cycles !== 5 || wr_done !== 1)
            $display("FAIL wb4_writes: got %0d/%0d expected 5/1", wr_cycles, wr_done); else passes++;
        checks++; if (stable_err !== 0) $display("FAIL wb4_stable: got %0d expected 0", stable_err); else passes++;
        checks++; if (cap_addr !== 32'h001234A0 || cap_data !== {32{8'hA5}})
            $display("FAIL wb4_bus: got %0h expected 1234a0", cap_addr); else passes++;
        resp_delay = 0;
    endtask

    task automatic test_clean_and_invalid();
        load_arrays(8'h04, 8'h08);
        run_sweep(1'b0);
        checks++; if (wr_cycles !== 0) $display("FAIL ci_nowrite: got %0d expected 0", wr_cycles); else passes++;
        checks++; if (v_mem !== 8'h00 || d_mem !== 8'h00)
            $display("FAIL ci_cleared: got %0h/%0h expected 0/0", v_mem, d_mem); else passes++;
        checks++; if (timed_out || busy_cycles !== 25) $display("FAIL ci_busy: got %0d expected 25", busy_cycles); else passes++;
    endtask

    task automatic test_req_during_check();
        int late_busy;
        load_arrays(8'h00, 8'h00);
        run_sweep(1'b1);
        checks++; if (done_cnt !== 1) $display("FAIL rq_done: got %0d expected 1", done_cnt); else passes++;
        checks++; if (timed_out || busy_cycles !== 25) $display("FAIL rq_busy: got %0d expected 25", busy_cycles); else passes++;
        late_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0) late_busy++;
            @(negedge clk);
        end
        checks++; if (late_busy !== 0) $display("FAIL rq_norestart: got %0d expected 0", late_busy); else passes++;
    endtask

    task automatic test_reset_mid_wb();
        bit found;
        int extra_done, extra_busy;
        load_arrays(8'hC0, 8'h40);
        resp_delay = 50;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (mem_write === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found || mem_address !== 32'hABCDEFC0)
            $display("FAIL rm_wb_addr: got %0h expected abcdefc0", mem_address); else passes++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if ({busy, flush_done, arr_read, arr_load, mem_write} !== 5'b00000)
            $display("FAIL rm_idle: got %b expected 00000", {busy, flush_done, arr_read, arr_load, mem_write}); else passes++;
        checks++; if (arr_index !== 3'd0 || mem_address !== 32'd0 || mem_wdata !== '0)
            $display("FAIL rm_bus: got %0h/%0h expected 0/0", arr_index, mem_address); else passes++;
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (flush_done !== 1'b0) extra_done++;
            if (busy !== 1'b0) extra_busy++;
            @(negedge clk);
        end
        checks++; if (extra_done !== 0 || extra_busy !== 0)
            $display("FAIL rm_quiet: got %0d/%0d expected 0/0", extra_done, extra_busy); else passes++;
        checks++; if (v_mem[7:6] !== 2'b11 || d_mem[6] !== 1'b1)
            $display("FAIL rm_untouched: got %b/%b expected 11/1", v_mem[7:6], d_mem[6]); else passes++;
        resp_delay = 0;
        run_sweep(1'b0);
        checks++; if (!first_read_ok) $display("FAIL rm_restart_idx0: got 0 expected 1"); else passes++;
        checks++; if (load_cnt !== 8 || wr_done !== 1 || cap_addr !== 32'hABCDEFC0)
            $display("FAIL rm_resweep: got %0d/%0d/%0h expected 8/1/abcdefc0", load_cnt, wr_done, cap_addr); else passes++;
        checks++; if (timed_out || busy_cycles !== 26 || done_cnt !== 1)
            $display("FAIL rm_resweep_busy: got %0d/%0d expected 26/1", busy_cycles, done_cnt); else passes++;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int late_busy;
        load_arrays(8'h00, 8'h00);
        @(negedge clk);
        flush_req = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (flush_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) $display("FAIL b2b_first_done: got 0 expected 1"); else passes++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || arr_read !== 1'b0)
            $display("FAIL b2b_idle_gap: got %b%b expected 00", busy, arr_read); else passes++;
        @(negedge clk);
        flush_req = 1'b0;
        checks++; if (busy !== 1'b1 || arr_read !== 1'b1 || arr_index !== 3'd0)
            $display("FAIL b2b_restart: got %b%b%0d expected 110", busy, arr_read, arr_index); else passes++;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (flush_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) $display("FAIL b2b_second_done: got 0 expected 1"); else passes++;
        late_busy = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0) late_busy++;
            @(negedge clk);
        end
        checks++; if (late_busy !== 0) $display("FAIL b2b_stop: got %0d expected 0", late_busy); else passes++;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush_req  = 1'b0;
        init_req   = 1'b0;
        init_valid = 8'h00;
        init_dirty = 8'h00;
        resp_delay = 0;
        for (int i = 0; i < 8; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_all_invalid();
        test_dirty_same_cycle();
        test_dirty_delayed();
        test_clean_and_invalid();
        test_req_during_check();
        test_reset_mid_wb();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_flush_engine.md
# l2_flush_engine

Sequential initiator for the L2 tag/valid/dirty/data arrays. It drives their read/load ports to sweep every set once on request. Each set that is both valid and dirty has its line written back to main memory, and every set is then cleared. It sits between the L2 controller (`flush_req`/`flush_done`) and the L2 arrays plus the memory write port, and owns the array ports only while `busy` is high.

## Interface
Parameters:
- `s_index`, default 3: set-index width; the block sweeps 2**s_index sets.
- `s_offset`, default 5: byte-offset width within a line.
- `s_tag`, default 32-s_index-s_offset: tag width.
- `s_line`, default 256: line width in bits.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `flush_req` in 1: start a sweep; sampled only in IDLE.
- `busy` out 1: high from READ through DONE inclusive.
- `flush_done` out 1: one-cycle pulse in DONE.
- `arr_read` out 1: read enable to all arrays.
- `arr_load` out 1: write enable to the valid and dirty arrays.
- `arr_index` out s_index: set index to all arrays.
- `arr_valid_in` out 1: datain to the valid array; always 0.
- `arr_dirty_in` out 1: datain to the dirty array; always 0.
- `valid_out` in 1: valid-array dataout.
- `dirty_out` in 1: dirty-array dataout.
- `tag_out` in s_tag: tag-array dataout.
- `data_out` in s_line: data-array dataout.
- `mem_write` out 1: write request to memory.
- `mem_address` out 32: {tag, index, s_offset zeros}.
- `mem_wdata` out s_line: line being written back.
- `mem_resp` in 1: memory write accepted/complete.

## Operation
- States: IDLE, READ, CHECK, WB, CLEAR, DONE.
- IDLE:
  - All outputs 0.
  - `flush_req`=1 → READ, with the index counter at 0.
- READ: `arr_read`=1, `arr_index`=counter → CHECK.
- CHECK:
  - Array dataouts are valid this cycle, because the arrays have registered reads with 1-cycle latency.
  - Latch `tag_out` and `data_out` into internal registers.
  - `valid_out`&&`dirty_out` → WB; otherwise → CLEAR.
- WB:
  - `mem_write`=1, `mem_address`={latched tag, counter, 0}, `mem_wdata`=latched data.
  - All three are held stable until `mem_resp`.
  - `mem_resp`=1 → CLEAR (the same-cycle response counts), else stay in WB.
- CLEAR: `arr_load`=1, `arr_index`=counter, valid/dirty datain=0.
  - Counter == 2**s_index-1 → DONE.
  - Otherwise the counter increments → READ.
- DONE: `flush_done`=1 → IDLE.
- Every set is cleared regardless of its state. Invalid and clean sets generate no memory traffic.
- The index counter is s_index bits wide. It never wraps during a sweep, because the last index exits to DONE.
- `flush_req` outside IDLE is ignored: no queuing, no restart.
- `mem_resp` outside WB is ignored.
- `arr_read` and `arr_load` are never high in the same cycle.

## Timing
- Reset: state=IDLE, counter=0, latches=0. Every output is 0, including `busy`, `flush_done`, `mem_write` and `arr_load`.
- `rst_n` low mid-sweep:
  - Abort to IDLE on the next edge, with no `flush_done`.
  - A pending `mem_write` drops.
  - Sets not yet cleared stay untouched.
- `flush_req` high at edge k while in IDLE → READ during cycle k+1.
- Per set: clean or invalid takes 3 cycles (READ, CHECK, CLEAR). Dirty takes 3+W cycles, where W≥1 is the number of WB cycles including the `mem_resp` cycle.
- Full clean sweep: busy for 3·2**s_index + 1 cycles; `flush_done` is in the last of these.
- Back-to-back sweeps: `flush_req` held high through DONE starts a new sweep from IDLE one cycle after DONE.

## Test plan
- All sets invalid, s_index=3, `flush_req` pulse → `busy` for 25 cycles; 8 `arr_load` pulses at indices 0..7; `mem_write` never asserted; one `flush_done`.
- Set 5 valid and dirty, tag 0x1234, data pattern A5…, `mem_resp` the same cycle → one `mem_write` with `mem_address`={0x1234,3'd5,5'd0}, `mem_wdata`=A5…; busy for 26 cycles.
- Same as the previous scenario but `mem_resp` delayed 4 cycles → `mem_write`, `mem_address` and `mem_wdata` are stable for all 5 WB cycles; busy for 30 cycles.
- Set 2 valid and clean, set 3 dirty but invalid → no `mem_write`; both sets cleared.
- `flush_req` re-pulsed during CHECK of set 4 → ignored; exactly one `flush_done`.
- `rst_n` low for 1 cycle during WB of set 6 → next cycle is IDLE with all outputs 0; no `flush_done`; a new `flush_req` restarts the sweep at index 0.
